// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared types and constants for the binary32 adder front end.
//  Revision    : 1.0
// ============================================================================
package fp_pkg;

  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int         MANT_W  = 24;
  localparam int         WORD_W  = 32;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic isNaN;
    logic isInf;
    logic isZero;
  } fpClass_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } fpState_t;

  // Any of these classes skips the arithmetic datapath entirely.
  function automatic logic isSpecial(input fpClass_t cls);
    return cls.isNaN | cls.isInf | cls.isZero;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational operand classifier and mantissa/exponent unpack.
//  Revision    : 1.0
// ============================================================================
module fp_classify
  import fp_pkg::*;
(
  input  fp32_t              op,
  output logic               sign,
  output fpClass_t           cls,
  output logic [WORD_W-1:0]  mant,
  output logic [7:0]         effExp
);

  logic w_expMax;
  logic w_expZero;
  logic w_fracZero;

  assign w_expMax   = (op.exp == EXP_MAX);
  assign w_expZero  = (op.exp == 8'd0);
  assign w_fracZero = (op.frac == 23'd0);

  assign sign       = op.sign;
  assign cls.isNaN  = w_expMax & ~w_fracZero;
  assign cls.isInf  = w_expMax & w_fracZero;
  assign cls.isZero = w_expZero & w_fracZero;

  // Subnormals have no hidden bit and behave as if their exponent were 1.
  assign mant   = {~w_expZero, op.frac, {(WORD_W-MANT_W){1'b0}}};
  assign effExp = w_expZero ? 8'd1 : op.exp;

endmodule
`default_nettype wire

// File: rtl/fp_align_add.sv
`default_nettype none
// ============================================================================
//  Module      : fp_align_add
//  Description : binary32 adder front end: classify, swap, iterative align, add.
//  Revision    : 1.0
// ============================================================================
module fp_align_add
  import fp_pkg::*;
#(
  parameter int ALIGN_STEP = 4,
  parameter int MAX_SHIFT  = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        signA,
  output logic        signB,
  output logic        ANaN,
  output logic        BNaN,
  output logic        Ainf,
  output logic        Binf,
  output logic        Azero,
  output logic        Bzero,
  output logic        alignedSign,
  output logic [31:0] alignedResult,
  output logic        carryOut,
  output logic [7:0]  exponentOut
);

  localparam logic [7:0] c_alignStep = 8'(ALIGN_STEP);
  localparam logic [7:0] c_maxShift  = 8'(MAX_SHIFT);

  fpState_t    r_state;
  fpState_t    w_nextState;

  fp32_t       r_a;
  fp32_t       r_b;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic        r_signX;
  logic        r_signY;
  logic [7:0]  r_remain;
  logic [7:0]  r_expOut;
  logic [31:0] r_result;
  logic        r_carry;
  logic        r_sign;
  fpClass_t    r_clsA;
  fpClass_t    r_clsB;

  logic        w_signA;
  logic        w_signB;
  fpClass_t    w_clsA;
  fpClass_t    w_clsB;
  logic [31:0] w_mantA;
  logic [31:0] w_mantB;
  logic [7:0]  w_effExpA;
  logic [7:0]  w_effExpB;

  fp_classify u_classA (
    .op     (r_a),
    .sign   (w_signA),
    .cls    (w_clsA),
    .mant   (w_mantA),
    .effExp (w_effExpA)
  );

  fp_classify u_classB (
    .op     (r_b),
    .sign   (w_signB),
    .cls    (w_clsB),
    .mant   (w_mantB),
    .effExp (w_effExpB)
  );

  // Swap so X holds the larger magnitude; a tie keeps A as X.
  logic        w_special;
  logic        w_aGeB;
  logic [31:0] w_mantX;
  logic [31:0] w_mantY;
  logic [7:0]  w_expX;
  logic [7:0]  w_expY;
  logic [7:0]  w_diff;
  logic [7:0]  w_shift;

  assign w_special = isSpecial(w_clsA) | isSpecial(w_clsB);
  assign w_aGeB    = ({r_a.exp, r_a.frac} >= {r_b.exp, r_b.frac});
  assign w_mantX   = w_aGeB ? w_mantA   : w_mantB;
  assign w_mantY   = w_aGeB ? w_mantB   : w_mantA;
  assign w_expX    = w_aGeB ? w_effExpA : w_effExpB;
  assign w_expY    = w_aGeB ? w_effExpB : w_effExpA;
  assign w_diff    = w_expX - w_expY;
  assign w_shift   = (w_diff > c_maxShift) ? c_maxShift : w_diff;

  // One alignment step; the wide shift keeps every dropped bit for the sticky.
  logic [7:0]  w_step;
  logic [95:0] w_wide;
  logic [31:0] w_alignedY;

  assign w_step     = (r_remain < c_alignStep) ? r_remain : c_alignStep;
  assign w_wide     = {r_y, 64'd0} >> w_step;
  assign w_alignedY = {w_wide[95:65], w_wide[64] | (|w_wide[63:0])};

  logic [32:0] w_sum;
  logic        w_cancel;

  assign w_sum    = (r_signX ^ r_signY) ? ({1'b0, r_x} - {1'b0, r_y})
                                        : ({1'b0, r_x} + {1'b0, r_y});
  assign w_cancel = (w_sum == 33'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = UNPACK;
      end
      UNPACK: begin
        if (w_special)              w_nextState = DONE;
        else if (w_shift != 8'd0)   w_nextState = ALIGN;
        else                        w_nextState = ADD;
      end
      ALIGN: begin
        if (r_remain <= c_alignStep) w_nextState = ADD;
      end
      ADD: begin
        w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_signX  <= 1'b0;
      r_signY  <= 1'b0;
      r_remain <= '0;
      r_expOut <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_sign   <= 1'b0;
      r_clsA   <= '0;
      r_clsB   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= fp32_t'(a);
            r_b <= fp32_t'(b);
          end
        end
        UNPACK: begin
          r_clsA <= w_clsA;
          r_clsB <= w_clsB;
          if (w_special) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_expOut <= '0;
            r_sign   <= 1'b0;
          end else begin
            r_x      <= w_mantX;
            r_y      <= w_mantY;
            r_signX  <= w_aGeB ? w_signA : w_signB;
            r_signY  <= w_aGeB ? w_signB : w_signA;
            r_remain <= w_shift;
            r_expOut <= w_expX;
          end
        end
        ALIGN: begin
          r_y      <= w_alignedY;
          r_remain <= r_remain - w_step;
        end
        ADD: begin
          r_result <= w_sum[31:0];
          r_carry  <= (r_signX == r_signY) ? w_sum[32] : 1'b0;
          if (w_cancel) begin
            r_sign   <= 1'b0;
            r_expOut <= '0;
          end else begin
            r_sign   <= r_signX;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign A             = r_a;
  assign B             = r_b;
  assign signA         = r_a.sign;
  assign signB         = r_b.sign;
  assign ANaN          = r_clsA.isNaN;
  assign BNaN          = r_clsB.isNaN;
  assign Ainf          = r_clsA.isInf;
  assign Binf          = r_clsB.isInf;
  assign Azero         = r_clsA.isZero;
  assign Bzero         = r_clsB.isZero;
  assign alignedSign   = r_sign;
  assign alignedResult = r_result;
  assign carryOut      = r_carry;
  assign exponentOut   = r_expOut;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_align_add
//  Description : Directed plus random checks of fp_align_add against a model.
//  Revision    : 1.0
// ============================================================================
module tb_fp_align_add;

  localparam int ALIGN_STEP = 4;
  localparam int MAX_SHIFT  = 34;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        signA, signB;
  logic        ANaN, BNaN, Ainf, Binf, Azero, Bzero;
  logic        alignedSign;
  logic [31:0] alignedResult;
  logic        carryOut;
  logic [7:0]  exponentOut;

  int nCmp  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  fp_align_add #(.ALIGN_STEP(ALIGN_STEP), .MAX_SHIFT(MAX_SHIFT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .signA(signA), .signB(signB),
    .ANaN(ANaN), .BNaN(BNaN), .Ainf(Ainf), .Binf(Binf), .Azero(Azero), .Bzero(Bzero),
    .alignedSign(alignedSign), .alignedResult(alignedResult),
    .carryOut(carryOut), .exponentOut(exponentOut)
  );

  typedef struct {
    logic [31:0] res;
    logic        carry;
    logic [7:0]  expo;
    logic        sign;
    logic [5:0]  flags;   // {ANaN,BNaN,Ainf,Binf,Azero,Bzero}
    int          edges;   // clock edges after the input handshake until out_valid
  } exp_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Whole-number model: one-shot shift by the exponent gap, sticky from the dropped bits.
  function automatic exp_t refModel(input logic [31:0] opA, input logic [31:0] opB);
    exp_t e;
    int   ea, eb, fa, fb, effA, effB, effX, effY, d, k;
    logic nanA, nanB, infA, infB, zA, zB, sx, sy;
    longint unsigned mA, mB, mx, my, lost, s;
    ea = int'(opA[30:23]); eb = int'(opB[30:23]);
    fa = int'(opA[22:0]);  fb = int'(opB[22:0]);
    nanA = (ea == 255) && (fa != 0); infA = (ea == 255) && (fa == 0); zA = (ea == 0) && (fa == 0);
    nanB = (eb == 255) && (fb != 0); infB = (eb == 255) && (fb == 0); zB = (eb == 0) && (fb == 0);
    e.flags = {nanA, nanB, infA, infB, zA, zB};
    e.res = 0; e.carry = 0; e.expo = 0; e.sign = 0; e.edges = 1;
    if (e.flags != 0) return e;
    effA = (ea == 0) ? 1 : ea;
    effB = (eb == 0) ? 1 : eb;
    mA = (longint'(ea != 0) * 64'h8000_0000) + longint'(fa) * 256;
    mB = (longint'(eb != 0) * 64'h8000_0000) + longint'(fb) * 256;
    if (opA[30:0] >= opB[30:0]) begin
      mx = mA; my = mB; effX = effA; effY = effB; sx = opA[31]; sy = opB[31];
    end else begin
      mx = mB; my = mA; effX = effB; effY = effA; sx = opB[31]; sy = opA[31];
    end
    d = effX - effY;
    if (d > MAX_SHIFT) d = MAX_SHIFT;
    k = (d + ALIGN_STEP - 1) / ALIGN_STEP;
    lost = my % (64'd1 << d);
    my   = my / (64'd1 << d);
    if (lost != 0) my = my | 64'd1;
    e.edges = 2 + k;
    if (sx == sy) begin
      s = mx + my;
      e.res = s[31:0]; e.carry = s[32]; e.sign = sx; e.expo = 8'(effX);
    end else begin
      s = mx - my;
      e.res = s[31:0];
      if (s == 0) begin e.sign = 0; e.expo = 0; end
      else begin e.sign = sx; e.expo = 8'(effX); end
    end
    return e;
  endfunction

  task automatic checkFields(input string tag, input exp_t e, input logic [31:0] opA, input logic [31:0] opB);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".inReady"}, 64'(in_ready), 64'd0);
    check({tag, ".A"}, 64'(A), 64'(opA));
    check({tag, ".B"}, 64'(B), 64'(opB));
    check({tag, ".signs"}, 64'({signA, signB}), 64'({opA[31], opB[31]}));
    check({tag, ".flags"}, 64'({ANaN, BNaN, Ainf, Binf, Azero, Bzero}), 64'(e.flags));
    check({tag, ".result"}, 64'(alignedResult), 64'(e.res));
    check({tag, ".carry"}, 64'(carryOut), 64'(e.carry));
    check({tag, ".exp"}, 64'(exponentOut), 64'(e.expo));
    check({tag, ".sign"}, 64'(alignedSign), 64'(e.sign));
  endtask

  // Entered #1 after an edge with the DUT idle; leaves it idle again.
  task automatic runOp(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                       input int hold, input bit junk);
    exp_t e;
    int   cnt;
    e = refModel(opA, opB);
    check({tag, ".readyBefore"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = opA; b = opB;
    @(posedge clk); #1;
    if (junk) begin
      a = ~opA; b = opB ^ 32'h0055_AA00;
    end else begin
      in_valid = 1'b0;
    end
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 64'(cnt), 64'(e.edges));
    checkFields(tag, e, opA, opB);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkFields({tag, ".hold"}, e, opA, opB);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".validAfter"}, 64'(out_valid), 64'd0);
    check({tag, ".readyAfter"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] randOp(input logic [7:0] baseExp);
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = int'($urandom_range(0, 15));
    f   = 23'($urandom);
    case (sel)
      0:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
      1:       begin e = 8'h00; f = '0; end
      2, 3:    e = 8'h00;
      4:       e = baseExp + 8'($urandom_range(20, 60));
      default: e = baseExp + 8'($urandom_range(0, 12));
    endcase
    if (sel > 4 && e == 8'hFF) e = 8'hFE;
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  base;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset.inReady", 64'(in_ready), 64'd1);
    check("reset.outValid", 64'(out_valid), 64'd0);
    check("reset.result", 64'(alignedResult), 64'd0);
    check("reset.AB", {A, B}, 64'd0);
    check("reset.misc", 64'({carryOut, exponentOut, alignedSign, signA, signB,
                             ANaN, BNaN, Ainf, Binf, Azero, Bzero}), 64'd0);
    reset = 1'b0;

    runOp("oneplusone", 32'h3F80_0000, 32'h3F80_0000, 0, 1'b0);
    runOp("gap10",      32'h3F80_0000, 32'h3A80_0000, 0, 1'b0);
    runOp("cancel",     32'h3F80_0000, 32'hBF80_0000, 0, 1'b0);
    runOp("nanA",       32'h7FC0_0000, 32'h3F80_0000, 0, 1'b0);
    runOp("subnCap",    32'h3F80_0000, 32'h0000_0001, 0, 1'b0);
    runOp("holdDone",   32'hC0A0_0000, 32'h3F40_0000, 5, 1'b0);
    runOp("swapBig",    32'h3A80_0000, 32'hBF80_0000, 0, 1'b1);
    runOp("infB",       32'h4120_0000, 32'hFF80_0000, 0, 1'b0);
    runOp("zeroes",     32'h0000_0000, 32'h8000_0000, 0, 1'b0);
    runOp("subSub",     32'h0040_0000, 32'h8000_0003, 0, 1'b0);

    // Reset landing in the middle of alignment.
    in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h3A80_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midAlignReset.outValid", 64'(out_valid), 64'd0);
    check("midAlignReset.inReady", 64'(in_ready), 64'd1);
    runOp("afterReset", 32'h3F80_0000, 32'h3F80_0000, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      base = 8'($urandom_range(1, 200));
      ra = randOp(base);
      rb = ($urandom_range(0, 7) == 0) ? (ra ^ 32'h8000_0000) : randOp(base);
      runOp($sformatf("rand%0d", i), ra, rb, int'($urandom_range(0, 2)), 1'(i % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire
